// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: RV32I-subset decode with register file, hazard stall and ID/EX register
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   ifIdInstruction, ifIdIn      instruction and PC+4 from IF/ID
//   flush                        branch taken in EX/MEM; squash this decode
//   wbRegWrite, wbRd, wbData     register file write port
//   stall                        combinational load-use stall back to fetch
//   idEx*                        registered ID/EX pipeline outputs
module instruction_decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     ifIdInstruction,
   input  logic [XLEN-1:0] ifIdIn,
   input  logic            flush,
   input  logic            wbRegWrite,
   input  logic [4:0]      wbRd,
   input  logic [XLEN-1:0] wbData,
   output logic            stall,
   output logic [XLEN-1:0] idExNpc,
   output logic [XLEN-1:0] idExRs1Data,
   output logic [XLEN-1:0] idExRs2Data,
   output logic [XLEN-1:0] idExImm,
   output logic [4:0]      idExRs1,
   output logic [4:0]      idExRs2,
   output logic [4:0]      idExRd,
   output logic [3:0]      idExAluOp,
   output logic            idExAluSrc,
   output logic            idExMemRead,
   output logic            idExMemWrite,
   output logic            idExRegWrite,
   output logic            idExMemToReg,
   output logic            idExBranch,
   output logic            idExIllegal
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                          ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_SLT = 4'd8;

   logic [XLEN-1:0] rf [NREGS];

   logic [6:0] op, f7;
   logic [2:0] f3;
   logic [4:0] rs1, rs2, rd;
   assign op  = ifIdInstruction[6:0];
   assign rd  = ifIdInstruction[11:7];
   assign f3  = ifIdInstruction[14:12];
   assign rs1 = ifIdInstruction[19:15];
   assign rs2 = ifIdInstruction[24:20];
   assign f7  = ifIdInstruction[31:25];

   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   assign imm_i = {{(XLEN-12){ifIdInstruction[31]}}, ifIdInstruction[31:20]};
   assign imm_s = {{(XLEN-12){ifIdInstruction[31]}}, ifIdInstruction[31:25], ifIdInstruction[11:7]};
   assign imm_b = {{(XLEN-13){ifIdInstruction[31]}}, ifIdInstruction[31], ifIdInstruction[7],
                   ifIdInstruction[30:25], ifIdInstruction[11:8], 1'b0};

   // funct3 -> ALU function, shared by R and I forms; funct7 only distinguishes SUB and SRA
   logic [3:0] alu_fn;
   logic       fn_ok, r_ok, i_ok;
   always_comb begin
      alu_fn = ALU_ADD;
      fn_ok  = 1'b1;
      case (f3)
         3'b000:  alu_fn = (op == OP_R && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         3'b111:  alu_fn = ALU_AND;
         default: fn_ok  = 1'b0;
      endcase
   end
   // R-type: funct7 must be 0, or the alternate encoding for SUB/SRA only.
   // I-type: funct7 is part of the immediate except for shifts.
   assign r_ok = fn_ok && (f7 == 7'd0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
   assign i_ok = fn_ok && ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'd0 || (f7 == F7_ALT && f3 == 3'b101));

   logic [3:0]      alu_op;
   logic [XLEN-1:0] imm;
   logic            alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, illegal, rs2_used;
   always_comb begin
      alu_op     = ALU_ADD;
      imm        = '0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b1;
      rs2_used   = 1'b0;
      case (op)
         OP_R: begin
            rs2_used = 1'b1;
            if (r_ok) begin
               alu_op    = alu_fn;
               reg_write = 1'b1;
               illegal   = 1'b0;
            end
         end
         OP_I: if (i_ok) begin
            alu_op    = alu_fn;
            alu_src   = 1'b1;
            reg_write = 1'b1;
            imm       = imm_i;
            illegal   = 1'b0;
         end
         OP_LOAD: if (f3 == 3'b010) begin
            alu_src    = 1'b1;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            imm        = imm_i;
            illegal    = 1'b0;
         end
         OP_STORE: begin
            rs2_used = 1'b1;
            if (f3 == 3'b010) begin
               alu_src   = 1'b1;
               mem_write = 1'b1;
               imm       = imm_s;
               illegal   = 1'b0;
            end
         end
         OP_BRANCH: begin
            rs2_used = 1'b1;
            if (f3 == 3'b000) begin
               alu_op  = ALU_SUB;
               branch  = 1'b1;
               imm     = imm_b;
               illegal = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // x0 reads zero; a same-cycle writeback to the read index is forwarded
   logic [XLEN-1:0] rs1_data, rs2_data;
   assign rs1_data = (rs1 == 5'd0) ? '0 : (wbRegWrite && wbRd == rs1) ? wbData : rf[rs1];
   assign rs2_data = (rs2 == 5'd0) ? '0 : (wbRegWrite && wbRd == rs2) ? wbData : rf[rs2];

   assign stall = idExMemRead && idExRd != 5'd0 &&
                  (idExRd == rs1 || (rs2_used && idExRd == rs2)) && !flush;

   logic bubble;
   assign bubble = stall || flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (wbRegWrite && wbRd != 5'd0) begin
         rf[wbRd] <= wbData;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset || bubble) begin
         idExNpc      <= '0;
         idExRs1Data  <= '0;
         idExRs2Data  <= '0;
         idExImm      <= '0;
         idExRs1      <= '0;
         idExRs2      <= '0;
         idExRd       <= '0;
         idExAluOp    <= '0;
         idExAluSrc   <= 1'b0;
         idExMemRead  <= 1'b0;
         idExMemWrite <= 1'b0;
         idExRegWrite <= 1'b0;
         idExMemToReg <= 1'b0;
         idExBranch   <= 1'b0;
         idExIllegal  <= 1'b0;
      end else begin
         idExNpc      <= ifIdIn;
         idExRs1Data  <= rs1_data;
         idExRs2Data  <= rs2_data;
         idExImm      <= imm;
         idExRs1      <= rs1;
         idExRs2      <= rs2;
         idExRd       <= rd;
         idExAluOp    <= alu_op;
         idExAluSrc   <= alu_src;
         idExMemRead  <= mem_read;
         idExMemWrite <= mem_write;
         idExRegWrite <= reg_write;
         idExMemToReg <= mem_to_reg;
         idExBranch   <= branch;
         idExIllegal  <= illegal;
      end
   end
endmodule
